// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus bridge and its lane aligner.
// Size, FSM state and completion error codes live here.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // Size 11 behaves as a word, so anything not byte/half needs word alignment.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            (size == SZ_B): r = 1'b0;
            (size == SZ_H): r = off[0];
            default:        r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane placement for stores and extract/extend for loads.
// Purely combinational; the two paths have independent inputs.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_lane,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;

    always_comb begin
        st_strb = 4'b1111;
        st_lane = st_data;
        unique case (1'b1)
            (st_size == SZ_B): begin
                st_strb = 4'b0001 << st_off;
                st_lane = {4{st_data[7:0]}};
            end
            (st_size == SZ_H): begin
                st_strb = st_off[1] ? 4'b1100 : 4'b0011;
                st_lane = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
        ld_sign = 1'b0;
        ld_data = ld_raw;
        unique case (1'b1)
            (ld_size == SZ_B): begin
                ld_sign = ~ld_unsigned & ld_byte[7];
                ld_data = {{24{ld_sign}}, ld_byte};
            end
            (ld_size == SZ_H): begin
                ld_sign = ~ld_unsigned & ld_half[15];
                ld_data = {{16{ld_sign}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// MEM-stage to req/ack bus bridge with lane alignment and bus timeout.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses with ERR_MISALIGN.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                TIMEOUT_CYC = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_stall,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [1:0]        err_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    lsu_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [3:0]        strb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic        misalign;
    logic        expired;
    logic        accept;
    logic        fin_ack;
    logic        fin_to;
    logic [3:0]  st_strb;
    logic [31:0] st_lane;
    logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(mem_size, mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Counter starts at 0 on the first REQ cycle, so TIMEOUT_CYC-1 marks the last one.
    assign expired = (TIMEOUT_CYC != 0) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    lsu_lane_align u_align (
        .st_size     (mem_size),
        .st_off      (mem_addr[1:0]),
        .st_data     (mem_wdata),
        .st_strb     (st_strb),
        .st_lane     (st_lane),
        .ld_size     (size_q),
        .ld_off      (addr_q[1:0]),
        .ld_unsigned (uns_q),
        .ld_raw      (bus_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ack   = 1'b0;
        fin_to    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    accept    = 1'b1;
                    state_nxt = misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    fin_ack   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (expired) begin
                    fin_to    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= RESET_ADDR;
            size_q  <= SZ_W;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            strb_q  <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr;
                size_q  <= mem_size;
                we_q    <= mem_we;
                uns_q   <= mem_unsigned;
                strb_q  <= st_strb;
                wdata_q <= st_lane;
                cnt_q   <= '0;
            end else if (state == ST_REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept && misalign) begin
                rdata_q <= '0;
                err_q   <= ERR_MISALIGN;
            end
            if (fin_ack) begin
                rdata_q <= ld_data;
                err_q   <= ERR_OK;
            end
            if (fin_to) begin
                rdata_q <= '0;
                err_q   <= ERR_TIMEOUT;
            end
        end
    end

    assign bus_req   = (state == ST_REQ);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : RESET_ADDR;
    assign bus_wstrb = bus_we ? strb_q : 4'b0000;
    assign bus_wdata = bus_req ? wdata_q : '0;

    assign mem_done  = (state == ST_DONE);
    assign mem_stall = mem_valid & ~mem_done;
    assign mem_rdata = rdata_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge with TIMEOUT_CYC=4.
// Cycle 0 is the cycle in which mem_valid is first presented.
module tb_lsu_bus_bridge;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [1:0]  err_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk;
    int n_fail;
    int done_cyc;
    int req_cyc;
    int stall_cyc;
    int unstable;
    logic        b_we;
    logic [31:0] b_addr;
    logic [3:0]  b_wstrb;
    logic [31:0] b_wdata;

    lsu_bus_bridge #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (4),
        .RESET_ADDR  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .err_code     (err_code),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents one access and answers the bus after ack_dly REQ cycles
    // (negative means never). Returns one cycle after mem_done.
    task automatic run_access(
        input logic        we,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input int          ack_dly,
        input logic [31:0] rd
    );
        int cyc;
        int seen;
        bit done;
        mem_valid    = 1'b1;
        mem_we       = we;
        mem_size     = sz;
        mem_unsigned = uns;
        mem_addr     = addr;
        mem_wdata    = wd;
        cyc = 0;
        seen = 0;
        done = 0;
        done_cyc = -1;
        req_cyc = 0;
        stall_cyc = 0;
        unstable = 0;
        b_we = 1'b0;
        b_addr = '0;
        b_wstrb = '0;
        b_wdata = '0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (mem_stall) stall_cyc++;
            if (mem_done) begin
                done = 1;
                done_cyc = cyc;
            end
            bus_ack = 1'b0;
            if (bus_req) begin
                if (seen == 0) begin
                    b_we    = bus_we;
                    b_addr  = bus_addr;
                    b_wstrb = bus_wstrb;
                    b_wdata = bus_wdata;
                end else if ({bus_we, bus_addr, bus_wstrb, bus_wdata} !==
                             {b_we, b_addr, b_wstrb, b_wdata}) begin
                    unstable++;
                end
                bus_ack   = (seen == ack_dly);
                bus_rdata = rd;
                seen++;
            end
            req_cyc = seen;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_ack   = 1'b0;
        mem_valid = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("done_pulse", 32'(mem_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        mem_valid = 1'b0;
        mem_we = 1'b0;
        mem_size = 2'b10;
        mem_unsigned = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", 32'(err_code), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_access(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 2, 32'h0);
        check("sb_addr", b_addr, 32'h1000);
        check("sb_we", 32'(b_we), 32'd1);
        check("sb_wstrb", 32'(b_wstrb), 32'h8);
        check("sb_wdata", b_wdata, 32'hABAB_ABAB);
        check("sb_done_cyc", done_cyc, 32'd4);
        check("sb_req_cyc", req_cyc, 32'd3);
        check("sb_stable", unstable, 32'd0);
        check("sb_err", 32'(err_code), 32'd0);

        run_access(1'b1, 2'b01, 1'b0, 32'h5002, 32'h1234_BEEF, 0, 32'h0);
        check("sh_wstrb", 32'(b_wstrb), 32'hC);
        check("sh_wdata", b_wdata, 32'hBEEF_BEEF);
        check("sh_addr", b_addr, 32'h5000);

        run_access(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 0, 32'h8001_0000);
        check("lh_rdata", mem_rdata, 32'hFFFF_8001);
        check("lh_wstrb", 32'(b_wstrb), 32'h0);
        check("lh_we", 32'(b_we), 32'd0);
        check("lh_addr", b_addr, 32'h2000);
        run_access(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 0, 32'h8001_0000);
        check("lhu_rdata", mem_rdata, 32'h0000_8001);
        check("lhu_err", 32'(err_code), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", mem_rdata, 32'h0000_8001);

        run_access(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 0, 32'h1234_5678);
        check("lw_rdata", mem_rdata, 32'h1234_5678);
        check("lw_done_cyc", done_cyc, 32'd2);
        check("lw_stall_cyc", stall_cyc, 32'd2);
        run_access(1'b0, 2'b00, 1'b0, 32'h4001, 32'h0, 0, 32'h0000_8000);
        check("b2b_done_cyc", done_cyc, 32'd2);
        check("b2b_rdata", mem_rdata, 32'hFFFF_FF80);

        run_access(1'b0, 2'b10, 1'b0, 32'h7000, 32'h0, -1, 32'hDEAD_BEEF);
        check("to_req_cyc", req_cyc, 32'd4);
        check("to_done_cyc", done_cyc, 32'd5);
        check("to_err", 32'(err_code), 32'd1);
        check("to_rdata", mem_rdata, 32'h0);

        mem_valid = 1'b1;
        mem_we = 1'b0;
        mem_size = 2'b10;
        mem_addr = 32'h6000;
        @(posedge clk);
        #1;
        check("mid_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_done", 32'(mem_done), 32'd0);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_req", 32'(bus_req), 32'd0);
            check("late_ack_done", 32'(mem_done), 32'd0);
            @(posedge clk);
            #1;
        end
        check("idle_addr", bus_addr, 32'h0);
        check("idle_rdata", mem_rdata, 32'h0);

        run_access(1'b1, 2'b10, 1'b0, 32'h3001, 32'hCAFE_F00D, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_req_cyc", req_cyc, 32'd0);
        check("mis_done_cyc", done_cyc, 32'd1);
        check("mis_err", 32'(err_code), 32'd2);
        check("mis_rdata", mem_rdata, 32'h0);
`else
        check("mis_wstrb", 32'(b_wstrb), 32'hF);
        check("mis_addr", b_addr, 32'h3000);
        check("mis_wdata", b_wdata, 32'hCAFE_F00D);
        check("mis_done_cyc", done_cyc, 32'd2);
        check("mis_err", 32'(err_code), 32'd0);
`endif

        run_access(1'b0, 2'b00, 1'b1, 32'h8002, 32'h0, 1, 32'h00F3_0000);
        check("lbu_rdata", mem_rdata, 32'h0000_00F3);
        check("lbu_done_cyc", done_cyc, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
